// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: shared widths, defaults and the write-back source select type.
`default_nettype none

package wb_arbiter_pkg;

    localparam int WB_FIFO_DEPTH = 4;
    localparam int WB_STARVE_MAX = 8;
    localparam int REG_BUS_W     = 32;
    localparam int REG_ADDR_W    = 5;
    localparam int WB_CNT_W      = 32;

    typedef enum logic [1:0] {
        SEL_NONE = 2'd0,
        SEL_ALU  = 2'd1,
        SEL_LOAD = 2'd2
    } wb_sel_e;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/wb_fifo.sv
// wb_fifo: load-result circular buffer with a per-entry squash bit and
// an rd compare-and-mark port that flags resident entries as stale.
`default_nettype none

module wb_fifo
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH  = WB_FIFO_DEPTH,
    parameter int XLEN   = REG_BUS_W,
    parameter int REG_AW = REG_ADDR_W,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic [REG_AW-1:0] i_push_rd,
    input  logic [XLEN-1:0]   i_push_data,
    input  logic              i_pop,
    input  logic              i_mark_en,
    input  logic [REG_AW-1:0] i_mark_rd,
    output logic [REG_AW-1:0] o_head_rd,
    output logic [XLEN-1:0]   o_head_data,
    output logic              o_head_sq,
    output logic [CW-1:0]     o_count
);

    logic [REG_AW-1:0] r_rd   [DEPTH];
    logic [XLEN-1:0]   r_data [DEPTH];
    logic [DEPTH-1:0]  r_sq;
    logic [PW-1:0]     r_head;
    logic [PW-1:0]     r_tail;
    logic [CW-1:0]     r_count;
    logic [DEPTH-1:0]  w_mark;

    // An entry is resident when its distance from head is below the count;
    // the slot being pushed this cycle is never resident, so it stays clean.
    for (genvar g = 0; g < DEPTH; g++) begin : g_mark
        logic [PW-1:0] w_off;
        assign w_off     = PW'(g) - r_head;
        assign w_mark[g] = i_mark_en && (r_rd[g] == i_mark_rd) && (CW'(w_off) < r_count);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_sq    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_rd[i]   <= '0;
                r_data[i] <= '0;
            end
        end else begin
            r_sq <= r_sq | w_mark;
            if (i_push) begin
                r_rd[r_tail]   <= i_push_rd;
                r_data[r_tail] <= i_push_data;
                r_sq[r_tail]   <= 1'b0;
                r_tail         <= r_tail + PW'(1);
            end
            if (i_pop) begin
                r_head <= r_head + PW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_head_rd   = r_rd[r_head];
    assign o_head_data = r_data[r_head];
    assign o_head_sq   = r_sq[r_head];
    assign o_count     = r_count;

endmodule

`default_nettype wire

// File: rtl/wb_arbiter.sv
// wb_arbiter: write-back port arbiter, ALU priority over buffered loads with
// stale-load squash and starvation stall. Optional counters under WB_PERF_EN.
`default_nettype none

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int DEPTH      = WB_FIFO_DEPTH,
    parameter int STARVE_MAX = WB_STARVE_MAX,
    parameter int XLEN       = REG_BUS_W,
    parameter int REG_AW     = REG_ADDR_W,
    localparam int CW        = cnt_width(DEPTH),
    localparam int SW        = $clog2(STARVE_MAX + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    output logic              alu_stall,
    input  logic              ld_valid,
    input  logic [REG_AW-1:0] ld_rd,
    input  logic [XLEN-1:0]   ld_data,
    output logic              ld_ready,
    output logic              we,
    output logic [REG_AW-1:0] waddr,
    output logic [XLEN-1:0]   wdata,
`ifdef WB_PERF_EN
    output logic [WB_CNT_W-1:0] perf_stall_cnt,
    output logic [WB_CNT_W-1:0] perf_squash_cnt,
`endif
    output logic [CW-1:0]     fifo_count
);

    logic              r_we;
    logic [REG_AW-1:0] r_waddr;
    logic [XLEN-1:0]   r_wdata;
    logic [SW-1:0]     r_starve;

    logic              w_stall;
    logic              w_alu_take;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_mark_en;
    wb_sel_e           w_sel;
    logic              w_we_nxt;
    logic [REG_AW-1:0] w_waddr_nxt;
    logic [XLEN-1:0]   w_wdata_nxt;
    logic [SW-1:0]     w_starve_nxt;
    logic [REG_AW-1:0] w_head_rd;
    logic [XLEN-1:0]   w_head_data;
    logic              w_head_sq;
    logic [CW-1:0]     w_count;

    wb_fifo #(
        .DEPTH  (DEPTH),
        .XLEN   (XLEN),
        .REG_AW (REG_AW)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .i_push      (w_push),
        .i_push_rd   (ld_rd),
        .i_push_data (ld_data),
        .i_pop       (w_pop),
        .i_mark_en   (w_mark_en),
        .i_mark_rd   (alu_rd),
        .o_head_rd   (w_head_rd),
        .o_head_data (w_head_data),
        .o_head_sq   (w_head_sq),
        .o_count     (w_count)
    );

    // The stall is a pure decode of the counter so it is glitch-free for upstream.
    assign w_stall    = (r_starve == SW'(STARVE_MAX));
    assign w_empty    = (w_count == '0);
    assign w_alu_take = alu_valid && !w_stall;
    assign w_push     = ld_valid && (w_count < CW'(DEPTH));
    assign w_pop      = (w_sel == SEL_LOAD);
    assign w_mark_en  = w_alu_take && (alu_rd != '0);

    always_comb begin
        w_sel        = SEL_NONE;
        w_we_nxt     = 1'b0;
        w_waddr_nxt  = '0;
        w_wdata_nxt  = '0;
        w_starve_nxt = r_starve;
        if (w_alu_take) begin
            w_sel = SEL_ALU;
        end else if (!w_empty) begin
            w_sel = SEL_LOAD;
        end
        case (w_sel)
            SEL_ALU: begin
                if (alu_rd != '0) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = alu_rd;
                    w_wdata_nxt = alu_data;
                end
            end
            SEL_LOAD: begin
                if (!w_head_sq && (w_head_rd != '0)) begin
                    w_we_nxt    = 1'b1;
                    w_waddr_nxt = w_head_rd;
                    w_wdata_nxt = w_head_data;
                end
            end
            default: ;
        endcase
        if (w_empty || w_pop) begin
            w_starve_nxt = '0;
        end else if (w_alu_take) begin
            w_starve_nxt = r_starve + SW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_we     <= 1'b0;
            r_waddr  <= '0;
            r_wdata  <= '0;
            r_starve <= '0;
        end else begin
            r_we     <= w_we_nxt;
            r_waddr  <= w_waddr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_starve <= w_starve_nxt;
        end
    end

`ifdef WB_PERF_EN
    logic [WB_CNT_W-1:0] r_perf_stall;
    logic [WB_CNT_W-1:0] r_perf_squash;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_perf_stall  <= '0;
            r_perf_squash <= '0;
        end else begin
            r_perf_stall  <= r_perf_stall + WB_CNT_W'(w_stall);
            r_perf_squash <= r_perf_squash + WB_CNT_W'(w_pop && w_head_sq);
        end
    end

    assign perf_stall_cnt  = r_perf_stall;
    assign perf_squash_cnt = r_perf_squash;
`endif

    assign alu_stall  = w_stall;
    assign ld_ready   = (w_count < CW'(DEPTH));
    assign we         = r_we;
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;
    assign fifo_count = w_count;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed vector table, hand sequences and randomized traffic
// checked against a queue-based reference model of the write-back arbiter.
`default_nettype none

module tb_wb_arbiter;

    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
    localparam int NVEC       = 19;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_stall;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  fifo_count;
`ifdef WB_PERF_EN
    logic [31:0] perf_stall_cnt;
    logic [31:0] perf_squash_cnt;
`endif

    wb_arbiter #(
        .DEPTH      (DEPTH),
        .STARVE_MAX (STARVE_MAX),
        .XLEN       (32),
        .REG_AW     (5)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .alu_valid       (alu_valid),
        .alu_rd          (alu_rd),
        .alu_data        (alu_data),
        .alu_stall       (alu_stall),
        .ld_valid        (ld_valid),
        .ld_rd           (ld_rd),
        .ld_data         (ld_data),
        .ld_ready        (ld_ready),
        .we              (we),
        .waddr           (waddr),
        .wdata           (wdata),
`ifdef WB_PERF_EN
        .perf_stall_cnt  (perf_stall_cnt),
        .perf_squash_cnt (perf_squash_cnt),
`endif
        .fifo_count      (fifo_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
        bit          sq;
    } ent_t;

    typedef struct {
        logic        av;
        logic [4:0]  ar;
        logic [31:0] ad;
        logic        lv;
        logic [4:0]  lr;
        logic [31:0] ld;
        logic        ewe;
        logic [4:0]  ewa;
        logic [31:0] ewd;
        logic [2:0]  ecnt;
        logic        erdy;
    } vec_t;

    ent_t        mq[$];
    int          m_starve;
    logic        m_we;
    logic [4:0]  m_wa;
    logic [31:0] m_wd;
    logic [31:0] m_pstall;
    logic [31:0] m_psq;
    int          n_checks;
    int          n_err;
    vec_t        tbl[NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        mq.delete();
        m_starve = 0;
        m_we     = 1'b0;
        m_wa     = '0;
        m_wd     = '0;
        m_pstall = '0;
        m_psq    = '0;
    endtask

    task automatic apply(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        alu_valid = av;
        alu_rd    = ar;
        alu_data  = ad;
        ld_valid  = lv;
        ld_rd     = lr;
        ld_data   = ld;
        #1;
    endtask

    // Compare against the model, advance the model by one cycle, then clock.
    task automatic tick();
        bit   stall, take, empty, pop, push;
        ent_t e;
        stall = (m_starve == STARVE_MAX);
        chk("we", {31'd0, we}, {31'd0, m_we});
        chk("waddr", {27'd0, waddr}, {27'd0, m_wa});
        chk("wdata", wdata, m_wd);
        chk("fifo_count", {29'd0, fifo_count}, mq.size());
        chk("ld_ready", {31'd0, ld_ready}, {31'd0, mq.size() < DEPTH});
        chk("alu_stall", {31'd0, alu_stall}, {31'd0, stall});
`ifdef WB_PERF_EN
        chk("perf_stall", perf_stall_cnt, m_pstall);
        chk("perf_squash", perf_squash_cnt, m_psq);
`endif
        take  = alu_valid && !stall;
        empty = (mq.size() == 0);
        pop   = !take && !empty;
        push  = ld_valid && (mq.size() < DEPTH);
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        if (take && alu_rd != 0) begin
            m_we = 1'b1;
            m_wa = alu_rd;
            m_wd = alu_data;
            foreach (mq[i]) if (mq[i].rd == alu_rd) mq[i].sq = 1'b1;
        end
        if (pop) begin
            e = mq.pop_front();
            if (!e.sq && e.rd != 0) begin
                m_we = 1'b1;
                m_wa = e.rd;
                m_wd = e.data;
            end
            if (e.sq) m_psq++;
        end
        if (push) mq.push_back('{ld_rd, ld_data, 1'b0});
        if (stall) m_pstall++;
        if (empty || pop) m_starve = 0;
        else if (take) m_starve++;
        @(posedge clk);
        #1;
    endtask

    task automatic cycle(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic lv, input logic [4:0] lr, input logic [31:0] ld);
        apply(av, ar, ad, lv, lr, ld);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int first_stall;
        int n_stall;
        n_checks = 0;
        n_err    = 0;
        m_reset();
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid  = 1'b0; ld_rd  = '0; ld_data  = '0;

        tbl[0]  = '{1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,        3'd0, 1'b1};
        tbl[1]  = '{1'b1, 5'd0, 32'h55,       1'b0, 5'd0, 32'h0,   1'b1, 5'd3, 32'hDEADBEEF, 3'd0, 1'b1};
        tbl[2]  = '{1'b1, 5'd0, 32'h0,        1'b1, 5'd1, 32'h101, 1'b0, 5'd0, 32'h0,        3'd0, 1'b1};
        tbl[3]  = '{1'b1, 5'd0, 32'h0,        1'b1, 5'd2, 32'h202, 1'b0, 5'd0, 32'h0,        3'd1, 1'b1};
        tbl[4]  = '{1'b1, 5'd0, 32'h0,        1'b1, 5'd4, 32'h404, 1'b0, 5'd0, 32'h0,        3'd2, 1'b1};
        tbl[5]  = '{1'b1, 5'd0, 32'h0,        1'b1, 5'd6, 32'h606, 1'b0, 5'd0, 32'h0,        3'd3, 1'b1};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd9, 32'h909, 1'b0, 5'd0, 32'h0,        3'd4, 1'b0};
        tbl[7]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd1, 32'h101,      3'd3, 1'b1};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd2, 32'h202,      3'd2, 1'b1};
        tbl[9]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd4, 32'h404,      3'd1, 1'b1};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd6, 32'h606,      3'd0, 1'b1};
        tbl[11] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,        3'd0, 1'b1};
        tbl[12] = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd5, 32'h55,  1'b0, 5'd0, 32'h0,        3'd0, 1'b1};
        tbl[13] = '{1'b1, 5'd5, 32'h11,       1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,        3'd1, 1'b1};
        tbl[14] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd5, 32'h11,       3'd1, 1'b1};
        tbl[15] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b0, 5'd0, 32'h0,        3'd0, 1'b1};
        tbl[16] = '{1'b1, 5'd7, 32'h77,       1'b1, 5'd7, 32'h70,  1'b0, 5'd0, 32'h0,        3'd0, 1'b1};
        tbl[17] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd7, 32'h77,       3'd1, 1'b1};
        tbl[18] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 32'h0,   1'b1, 5'd7, 32'h70,       3'd0, 1'b1};

        // Reset state
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_we", {31'd0, we}, 32'd0);
        chk("rst_waddr", {27'd0, waddr}, 32'd0);
        chk("rst_wdata", wdata, 32'd0);
        chk("rst_stall", {31'd0, alu_stall}, 32'd0);
        chk("rst_ready", {31'd0, ld_ready}, 32'd1);
        chk("rst_count", {29'd0, fifo_count}, 32'd0);
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;

        // Directed vector table
        for (int i = 0; i < NVEC; i++) begin
            apply(tbl[i].av, tbl[i].ar, tbl[i].ad, tbl[i].lv, tbl[i].lr, tbl[i].ld);
            chk($sformatf("vec%0d_we", i), {31'd0, we}, {31'd0, tbl[i].ewe});
            chk($sformatf("vec%0d_waddr", i), {27'd0, waddr}, {27'd0, tbl[i].ewa});
            chk($sformatf("vec%0d_wdata", i), wdata, tbl[i].ewd);
            chk($sformatf("vec%0d_count", i), {29'd0, fifo_count}, {29'd0, tbl[i].ecnt});
            chk($sformatf("vec%0d_ready", i), {31'd0, ld_ready}, {31'd0, tbl[i].erdy});
            tick();
        end

        // Starvation: one load buffered, ALU busy every cycle
        cycle(1'b1, 5'd11, 32'hA000, 1'b1, 5'd10, 32'hA0A0);
        first_stall = -1;
        n_stall     = 0;
        for (int k = 1; k <= 12; k++) begin
            apply(1'b1, 5'd11, 32'hA000 + 32'(k), 1'b0, 5'd0, 32'h0);
            if (alu_stall) begin
                n_stall++;
                if (first_stall < 0) first_stall = k;
            end
            tick();
        end
        chk("starve_first", first_stall, 32'd9);
        chk("starve_count", n_stall, 32'd1);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            cycle($urandom_range(0, 9) < 7, 5'($urandom_range(0, 7)), $urandom,
                  1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
        end

        // Asynchronous reset with entries buffered and a write pending
        for (int n = 0; n < 6; n++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        cycle(1'b1, 5'd0, 32'h0, 1'b1, 5'd13, 32'hD13);
        cycle(1'b1, 5'd0, 32'h0, 1'b1, 5'd14, 32'hD14);
        cycle(1'b1, 5'd0, 32'h0, 1'b1, 5'd15, 32'hD15);
        cycle(1'b1, 5'd12, 32'hC0C0, 1'b0, 5'd0, 32'h0);
        chk("prerst_count", {29'd0, fifo_count}, 32'd3);
        chk("prerst_we", {31'd0, we}, 32'd1);
        apply(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        rst = 1'b0;
        #1;
        chk("arst_we", {31'd0, we}, 32'd0);
        chk("arst_waddr", {27'd0, waddr}, 32'd0);
        chk("arst_wdata", wdata, 32'd0);
        chk("arst_count", {29'd0, fifo_count}, 32'd0);
        chk("arst_ready", {31'd0, ld_ready}, 32'd1);
        m_reset();
        @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int n = 0; n < 4; n++) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

`default_nettype wire
